dfm_measure_mc: RTL and testbench

Multi-channel reciprocal frequency meter. It counts signal rising edges and reference clk_i cycles over a programmable gate. The gate is aligned to signal edges at both ends, so sig_cnt/clk_cnt give an exact frequency ratio.
Each channel runs an independent measurement FSM with single-shot or continuous mode, a no-signal timeout and saturating counters. Finished results from all channels are merged round-robin onto one register-write port feeding the AXI register bank.

---
 rtl/dfm_measure_mc.sv | 257 +++++++++++++++++++++++++
 tb/tb_dfm_measure_mc.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfm_measure_mc.sv
// dfm_measure_mc: multi-channel reciprocal frequency meter.
// Each channel counts signal rising edges and clk_i cycles over a gate whose
// both ends are aligned to signal edges; results are merged round-robin onto
// a single register-write port.
// Build option: define MEASURE_SYNC_EN to insert a 2-flop synchroniser on
// sig_clk_i ahead of edge detection.
module dfm_measure_mc #(
  parameter int CH_NUM     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 32,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CH_NUM-1:0]      sig_clk_i,
  input  logic [CH_NUM-1:0]      ch_en_i,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic [GATE_WIDTH-1:0]  gate_time_i,
  output logic [CH_NUM-1:0]      busy_o,
  output logic                   reg_wr_en_o,
  output logic [CH_W-1:0]        reg_wr_ch_o,
  output logic [1:0]             reg_wr_flag_o,
  output logic [2*CNT_WIDTH-1:0] reg_wr_data_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_STOP,
    ST_DONE
  } state_t;

  logic [CH_NUM-1:0] sig_src;
  logic [CH_NUM-1:0] s_q, s_dq, rise;

  logic [CH_NUM-1:0]      pend_q, load, req, grant;
  logic [2*CNT_WIDTH-1:0] live_data [CH_NUM];
  logic [2*CNT_WIDTH-1:0] hold_data [CH_NUM];
  logic [1:0]             live_flag [CH_NUM];
  logic [1:0]             hold_flag [CH_NUM];
  logic [CH_W-1:0]        ptr_q, gnt_idx;
  logic                   gnt_vld;
  logic [2*CNT_WIDTH-1:0] sel_data;
  logic [1:0]             sel_flag;

`ifdef MEASURE_SYNC_EN
  logic [CH_NUM-1:0] sync1_q, sync2_q;

  // two-flop synchroniser for inputs asynchronous to clk_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig_clk_i;
      sync2_q <= sync1_q;
    end
  end

  assign sig_src = sync2_q;
`else
  assign sig_src = sig_clk_i;
`endif

  // edge detector: one sampling stage plus a delayed copy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q  <= '0;
      s_dq <= '0;
    end else begin
      s_q  <= sig_src;
      s_dq <= s_q;
    end
  end

  assign rise = s_q & ~s_dq;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t                state_q, state_d;
    logic [GATE_WIDTH-1:0] gate_q, gate_d, wait_q, wait_d, gcnt_q, gcnt_d;
    logic [CNT_WIDTH-1:0]  sig_q, sig_d, clk_q, clk_d;
    logic                  tmo_q, tmo_d, ovf_q, ovf_d;

    // channel state, gate and count registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q <= ST_IDLE;
        gate_q  <= '0;
        wait_q  <= '0;
        gcnt_q  <= '0;
        sig_q   <= '0;
        clk_q   <= '0;
        tmo_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        gate_q  <= gate_d;
        wait_q  <= wait_d;
        gcnt_q  <= gcnt_d;
        sig_q   <= sig_d;
        clk_q   <= clk_d;
        tmo_q   <= tmo_d;
        ovf_q   <= ovf_d;
      end
    end

    // measurement FSM: next state, gate timing and saturating counters
    always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      wait_d  = wait_q;
      gcnt_d  = gcnt_q;
      sig_d   = sig_q;
      clk_d   = clk_q;
      tmo_d   = tmo_q;
      ovf_d   = ovf_q;
      case (state_q)
        ST_IDLE: begin
          if (start_i && ch_en_i[g]) begin
            gate_d  = (gate_time_i == '0) ? GATE_WIDTH'(1) : gate_time_i;
            wait_d  = '0;
            sig_d   = '0;
            clk_d   = '0;
            tmo_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (rise[g]) begin
            sig_d   = '0;
            clk_d   = '0;
            gcnt_d  = '0;
            state_d = ST_MEAS;
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_d == gate_q) begin
              tmo_d   = 1'b1;
              sig_d   = '0;
              clk_d   = '0;
              state_d = ST_DONE;
            end
          end
        end
        ST_MEAS: begin
          gcnt_d = gcnt_q + 1'b1;
          if (gcnt_d == gate_q) begin
            wait_d  = '0;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (rise[g]) begin
            state_d = ST_DONE;
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_d == gate_q) begin
              tmo_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!pend_q[g]) begin
            if (cont_i) begin
              wait_d  = '0;
              sig_d   = '0;
              clk_d   = '0;
              tmo_d   = 1'b0;
              ovf_d   = 1'b0;
              state_d = ST_ARM;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_q == ST_MEAS || state_q == ST_STOP) begin
        if (clk_q == '1) ovf_d = 1'b1;
        else             clk_d = clk_q + 1'b1;
        if (rise[g]) begin
          if (sig_q == '1) ovf_d = 1'b1;
          else             sig_d = sig_q + 1'b1;
        end
      end
    end

    assign busy_o[g]    = (state_q != ST_IDLE);
    assign load[g]      = (state_q == ST_DONE) && !pend_q[g];
    assign live_data[g] = {clk_q, sig_q};
    assign live_flag[g] = {tmo_q, ovf_q};

    // result hold register, captured when DONE hands over its result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        hold_data[g] <= '0;
        hold_flag[g] <= '0;
      end else if (load[g]) begin
        hold_data[g] <= live_data[g];
        hold_flag[g] <= live_flag[g];
      end
    end
  end

  // A channel loading its result this cycle already requests the port and is
  // served straight from its live counters, giving the 2-cycle write latency.
  assign req = pend_q | load;

  // round-robin pick of the first requester at or after ptr_q
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    grant    = '0;
    sel_data = '0;
    sel_flag = '0;
    for (int unsigned i = 0; i < unsigned'(CH_NUM); i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= unsigned'(CH_NUM)) idx = idx - unsigned'(CH_NUM);
      if (!gnt_vld && req[CH_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (gnt_vld) begin
      grant[gnt_idx] = 1'b1;
      sel_data = pend_q[gnt_idx] ? hold_data[gnt_idx] : live_data[gnt_idx];
      sel_flag = pend_q[gnt_idx] ? hold_flag[gnt_idx] : live_flag[gnt_idx];
    end
  end

  // pending bits, rotating pointer and registered write port
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q        <= '0;
      ptr_q         <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_ch_o   <= '0;
      reg_wr_flag_o <= '0;
      reg_wr_data_o <= '0;
    end else begin
      pend_q      <= (pend_q | load) & ~grant;
      reg_wr_en_o <= gnt_vld;
      if (gnt_vld) begin
        reg_wr_ch_o   <= gnt_idx;
        reg_wr_flag_o <= sel_flag;
        reg_wr_data_o <= sel_data;
        ptr_q         <= (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfm_measure_mc.sv
// Self-checking bench for dfm_measure_mc: periodic stimulus generators and an
// arithmetic model of the edge-aligned gate.
module tb_dfm_measure_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sig, ch_en, busy;
  logic        start, cont;
  logic [31:0] gate;
  logic        wr_en;
  logic [1:0]  wr_ch, wr_flag;
  logic [63:0] wr_data;
  logic [1:0]  sig8, ch_en8, busy8;
  logic        wr_en8, wr_ch8;
  logic [1:0]  wr_flag8;
  logic [15:0] wr_data8;

  dfm_measure_mc #(.CH_NUM(4), .CNT_WIDTH(32), .GATE_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sig_clk_i(sig), .ch_en_i(ch_en),
    .start_i(start), .cont_i(cont), .gate_time_i(gate), .busy_o(busy),
    .reg_wr_en_o(wr_en), .reg_wr_ch_o(wr_ch), .reg_wr_flag_o(wr_flag),
    .reg_wr_data_o(wr_data)
  );

  dfm_measure_mc #(.CH_NUM(2), .CNT_WIDTH(8), .GATE_WIDTH(16)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .sig_clk_i(sig8), .ch_en_i(ch_en8),
    .start_i(start), .cont_i(cont), .gate_time_i(gate[15:0]), .busy_o(busy8),
    .reg_wr_en_o(wr_en8), .reg_wr_ch_o(wr_ch8), .reg_wr_flag_o(wr_flag8),
    .reg_wr_data_o(wr_data8)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int per [5];   // 0..3: dut channels, 4: dut8 channel 0; 0 = held low
  int ph  [5];
  logic [67:0] q_rec[$];   // {ch, flags, clk_cnt, sig_cnt}
  int          q_cyc[$];
  logic [18:0] q8_rec[$];  // {ch, flags, clk_cnt, sig_cnt}

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // periodic square-wave generators, one rising edge every per[c] cycles
  initial begin
    logic lvl;
    int   half;
    sig  = '0;
    sig8 = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
        if (per[c] == 0) lvl = 1'b0;
        else begin
          half  = (per[c] > 1) ? per[c] / 2 : 1;
          lvl   = (ph[c] < half);
          ph[c] = (ph[c] + 1) % per[c];
        end
        if (c < 4) sig[c] = lvl;
        else       sig8[0] = lvl;
      end
    end
  end

  // write-port monitor
  initial forever begin
    @(negedge clk);
    if (wr_en === 1'b1) begin
      q_rec.push_back({wr_ch, wr_flag, wr_data});
      q_cyc.push_back(cyc);
    end
    if (wr_en8 === 1'b1) q8_rec.push_back({wr_ch8, wr_flag8, wr_data8});
  end

  // Expected {timeout, overflow, clk_cnt, sig_cnt} for a periodic input of
  // period p (0 = no edges), gate g (0 means 1), w-bit counters. The gate
  // opens on an edge, spans g cycles, and closes on the next edge, which
  // must arrive within g further cycles.
  function automatic logic [65:0] model(int p, int g, int w);
    longint gg, k, clk_c, sig_c, mx;
    logic   tmo, ovf;
    gg = (g == 0) ? 1 : g;
    if (p == 0) return {2'b10, 64'd0};
    k = gg / p;
    if ((k + 1) * p <= 2 * gg) begin
      clk_c = (k + 1) * p; sig_c = k + 1; tmo = 1'b0;
    end else begin
      clk_c = 2 * gg; sig_c = k; tmo = 1'b1;
    end
    mx  = (longint'(1) << w) - 1;
    ovf = (clk_c > mx) || (sig_c > mx);
    if (clk_c > mx) clk_c = mx;
    if (sig_c > mx) sig_c = mx;
    return {tmo, ovf, clk_c[31:0], sig_c[31:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    ch_en = '0; ch_en8 = '0; gate = '0;
    for (int c = 0; c < 5; c++) begin per[c] = 0; ph[c] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q_rec.delete(); q_cyc.delete(); q8_rec.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && q_rec.size() < n; i++) @(posedge clk);
    ok = (q_rec.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_en = '1; ch_en8 = '1; gate = 32'd5;
    per[0] = 3; per[1] = 4; per[4] = 2;
    repeat (2) begin @(posedge clk); #1 start = 1'b1; @(posedge clk); #1 start = 1'b0; end
    n_assert++;
    if ({busy, wr_en, wr_ch, wr_flag, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, wr_en, wr_ch, wr_flag, wr_data});
    end
    n_assert++;
    if ({busy8, wr_en8, wr_ch8, wr_flag8, wr_data8} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got %h required 0", {busy8, wr_en8, wr_ch8, wr_flag8, wr_data8});
    end
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    n_assert++;
    if (q_rec.size() != 0 || busy !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: writes %0d busy %b required 0 and 0000", q_rec.size(), busy);
    end
  endtask

  task automatic test_single();
    int s; bit ok; logic [67:0] exp, rec;
    do_reset();
    per[0] = 10; gate = 32'd100; ch_en = 4'b0001;
    pulse_start(s);
    n_assert++;
    if (busy !== 4'b0001) begin
      n_fail++; $display("FAIL single_busy: got %b required 0001", busy);
    end
    wait_wr(1, 500, ok);
    exp = {2'd0, model(10, 100, 32)};
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL single_write: got no write required 1 write");
    end else begin
      rec = q_rec.pop_front();
      void'(q_cyc.pop_front());
      if (rec !== exp) begin
        n_fail++; $display("FAIL single_data: got %h required %h", rec, exp);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    n_assert++;
    if ({wr_en, wr_ch, wr_flag, wr_data} !== {1'b0, exp} || busy !== 4'b0) begin
      n_fail++;
      $display("FAIL single_hold: got %h busy %b required %h busy 0000", {wr_en, wr_ch, wr_flag, wr_data}, busy, {1'b0, exp});
    end
    repeat (300) @(posedge clk);
    n_assert++;
    if (q_rec.size() != 0) begin
      n_fail++; $display("FAIL single_shot: got %0d extra writes required 0", q_rec.size());
    end
  endtask

  // held-low channel: ARM times out after the latched gate (0 acts as 1)
  task automatic test_arm_timeout(input int ch, input int g);
    int s, gg; bit ok; logic [67:0] exp, rec;
    gg = (g == 0) ? 1 : g;
    do_reset();
    gate = 32'(g); ch_en = '0; ch_en[ch] = 1'b1;
    pulse_start(s);
    wait_wr(1, gg + 50, ok);
    exp = {2'(ch), model(0, g, 32)};
    n_assert += 2;
    if (!ok) begin
      n_fail += 2; $display("FAIL arm_timeout_g%0d: got no write required 1 write", g);
    end else begin
      rec = q_rec.pop_front();
      if (rec !== exp) begin
        n_fail++; $display("FAIL arm_timeout_data_g%0d: got %h required %h", g, rec, exp);
      end
      if (q_cyc[0] - s != gg + 2) begin
        n_fail++; $display("FAIL arm_timeout_time_g%0d: got %0d required %0d", g, q_cyc[0] - s, gg + 2);
      end
      void'(q_cyc.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int s, p, g; bit ok; logic [67:0] r0, r2; logic [65:0] m;
    do_reset();
    p = $urandom_range(2, 20);
    g = $urandom_range(p, 60);
    per[0] = p; per[2] = p; gate = 32'(g); ch_en = 4'b0101;
    pulse_start(s);
    wait_wr(2, 3 * g + 50, ok);
    m = model(p, g, 32);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_writes: got %0d writes required 2", q_rec.size());
    end else begin
      r0 = q_rec.pop_front(); r2 = q_rec.pop_front();
      n_assert += 3;
      if (r0 !== {2'd0, m}) begin
        n_fail++; $display("FAIL b2b_first: got %h required %h", r0, {2'd0, m});
      end
      if (r2 !== {2'd2, m}) begin
        n_fail++; $display("FAIL b2b_second: got %h required %h", r2, {2'd2, m});
      end
      if (q_cyc[1] - q_cyc[0] != 1) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d required 1", q_cyc[1] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_continuous();
    int s; bit ok; logic [67:0] rec, exp; logic [65:0] m; int interval;
    do_reset();
    per[0] = 7; gate = 32'd70; ch_en = 4'b0001; cont = 1'b1;
    m = model(7, 70, 32);
    exp = {2'd0, m};
    interval = int'(m[63:32]) + 7;  // closing edge, DONE, re-arm, next edge
    pulse_start(s);
    wait_wr(3, 3 * interval + 200, ok);
    cont = 1'b0;
    if (ok) wait_wr(4, interval + 100, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL cont_writes: got %0d writes required 4", q_rec.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        rec = q_rec[i];
        n_assert++;
        if (rec !== exp) begin
          n_fail++; $display("FAIL cont_data%0d: got %h required %h", i, rec, exp);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_assert++;
        if (q_cyc[i] - q_cyc[i-1] != interval) begin
          n_fail++; $display("FAIL cont_interval%0d: got %0d required %0d", i, q_cyc[i] - q_cyc[i-1], interval);
        end
      end
    end
    repeat (300) @(posedge clk);
    #1;
    n_assert++;
    if (q_rec.size() != 4 || busy !== 4'b0) begin
      n_fail++; $display("FAIL cont_stop: got %0d writes busy %b required 4 and 0000", q_rec.size(), busy);
    end
  endtask

  task automatic test_random();
    int s, g; bit ok; logic [67:0] rec; logic [3:0] seen; int ch;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      g = $urandom_range(16, 64);
      for (int c = 0; c < 4; c++) per[c] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 16);
      gate = 32'(g); ch_en = 4'hF;
      pulse_start(s);
      wait_wr(4, 3 * g + 60, ok);
      seen = '0;
      while (q_rec.size() > 0) begin
        rec = q_rec.pop_front();
        ch  = int'(rec[67:66]);
        seen[ch] = 1'b1;
        n_assert++;
        if (rec[65:0] !== model(per[ch], g, 32)) begin
          n_fail++;
          $display("FAIL random%0d_ch%0d: got %h required %h (period %0d gate %0d)", it, ch, rec[65:0], model(per[ch], g, 32), per[ch], g);
        end
      end
      n_assert++;
      if (!ok || seen !== 4'hF) begin
        n_fail++; $display("FAIL random%0d_channels: got %b required 1111", it, seen);
      end
    end
  endtask

  // single edge opens the gate, nothing closes it: STOP times out
  task automatic test_stop_timeout();
    int s; bit ok; logic [67:0] exp, rec;
    do_reset();
    gate = 32'd20; ch_en = 4'b0001;
    pulse_start(s);
    per[0] = 1000; ph[0] = 0;
    wait_wr(1, 200, ok);
    exp = {2'd0, model(1000, 20, 32)};
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL stop_timeout: got no write required %h", exp);
    end else begin
      rec = q_rec.pop_front();
      if (rec !== exp) begin
        n_fail++; $display("FAIL stop_timeout: got %h required %h", rec, exp);
      end
    end
  endtask

  task automatic test_saturation();
    int s; logic [65:0] m; logic [18:0] exp, rec;
    do_reset();
    per[4] = 2; gate = 32'd300; ch_en8 = 2'b01;
    pulse_start(s);
    for (int i = 0; i < 1200 && q8_rec.size() == 0; i++) @(posedge clk);
    m = model(2, 300, 8);
    exp = {1'b0, m[65:64], m[39:32], m[7:0]};
    n_assert++;
    if (q8_rec.size() == 0) begin
      n_fail++; $display("FAIL saturation: got no write required %h", exp);
    end else begin
      rec = q8_rec.pop_front();
      if (rec !== exp) begin
        n_fail++; $display("FAIL saturation: got %h required %h", rec, exp);
      end
    end
    n_assert++;
    if (q_rec.size() != 0) begin
      n_fail++; $display("FAIL saturation_main_quiet: got %0d writes required 0", q_rec.size());
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok; logic [67:0] exp, rec;
    do_reset();
    per[0] = 10; gate = 32'd100; ch_en = 4'b0001;
    pulse_start(s);
    repeat (50) @(posedge clk);
    #1;
    n_assert++;
    if (busy !== 4'b0001) begin
      n_fail++; $display("FAIL reset_mid_busy: got %b required 0001", busy);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, wr_en, wr_ch, wr_flag, wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h required 0", {busy, wr_en, wr_ch, wr_flag, wr_data});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (400) @(posedge clk);
    n_assert++;
    if (q_rec.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_nowrite: got %0d writes required 0", q_rec.size());
    end
    pulse_start(s);
    wait_wr(1, 500, ok);
    exp = {2'd0, model(10, 100, 32)};
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL reset_mid_restart: got no write required %h", exp);
    end else begin
      rec = q_rec.pop_front();
      if (rec !== exp) begin
        n_fail++; $display("FAIL reset_mid_restart: got %h required %h", rec, exp);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 5; c++) begin per[c] = 0; ph[c] = 0; end
    test_reset();
    test_single();
    test_arm_timeout(1, 50);
    test_arm_timeout(3, 0);
    test_back_to_back();
    test_continuous();
    test_random();
    test_stop_timeout();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
